// File: rtl/it_cond_unit_if.sv
// Bundle between the execute stage / xPSR and the IT-block condition unit.
// The flag nibble is ordered {N, Z, C, V} to match APSR[31:28].
interface it_cond_unit_if;
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    alu_flags_t  apsr_flags;
    alu_flags_t  alu_flags;
    logic        flag_we;
    logic        it_load;
    logic [3:0]  it_firstcond;
    logic [3:0]  it_mask;
    logic        instr_retire;
    logic [3:0]  instr_cond;
    logic        exc_entry;
    logic [7:0]  itstate;
    logic        in_it;
    logic        last_in_it;
    logic        cond_pass;
    logic        it_fault;

    modport master (
        output apsr_flags, alu_flags, flag_we, it_load, it_firstcond, it_mask,
               instr_retire, instr_cond, exc_entry,
        input  itstate, in_it, last_in_it, cond_pass, it_fault
    );

    modport slave (
        input  apsr_flags, alu_flags, flag_we, it_load, it_firstcond, it_mask,
               instr_retire, instr_cond, exc_entry,
        output itstate, in_it, last_in_it, cond_pass, it_fault
    );
endinterface

// File: rtl/it_cond_unit.sv
// ITSTATE holder and condition evaluator. Define IT_FLAG_FWD_EN to let the
// evaluator see flags being written to xPSR in the same cycle.
module it_cond_unit (
    input  logic           clk,
    input  logic           rst,
    it_cond_unit_if.slave  bus
);

    logic [7:0] itstate_q;
    logic [7:0] itstate_d;
    logic       fault_q;
    logic       fault_d;
    logic       in_it_w;
    logic [3:0] flags_sel;
    logic [3:0] cond_sel;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = !z;
            4'b0010: cond_eval = c;
            4'b0011: cond_eval = !c;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = !n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = !v;
            4'b1000: cond_eval = c & !z;
            4'b1001: cond_eval = !c | z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = !z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            default: cond_eval = 1'b1;
        endcase
    endfunction

`ifdef IT_FLAG_FWD_EN
    assign flags_sel = bus.flag_we ? bus.alu_flags : bus.apsr_flags;
`else
    assign flags_sel = bus.apsr_flags;
    logic unused_fwd;
    assign unused_fwd = ^{bus.alu_flags, bus.flag_we};
`endif

    assign in_it_w = (itstate_q[3:0] != 4'b0000);

    always_comb begin
        itstate_d = itstate_q;
        fault_d   = 1'b0;
        if (bus.exc_entry) begin
            itstate_d = 8'h00;
        end else if (bus.it_load) begin
            // A nested or empty-mask IT leaves the block untouched and flags a fault.
            if ((bus.it_mask == 4'b0000) || in_it_w)
                fault_d = 1'b1;
            else
                itstate_d = {bus.it_firstcond, bus.it_mask};
        end else if (bus.instr_retire && in_it_w) begin
            if (itstate_q[2:0] == 3'b000)
                itstate_d = 8'h00;
            else
                itstate_d = {itstate_q[7:5], itstate_q[3:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            itstate_q <= 8'h00;
            fault_q   <= 1'b0;
        end else begin
            itstate_q <= itstate_d;
            fault_q   <= fault_d;
        end
    end

    assign cond_sel       = in_it_w ? itstate_q[7:4] : bus.instr_cond;
    assign bus.itstate    = itstate_q;
    assign bus.in_it      = in_it_w;
    assign bus.last_in_it = (itstate_q[3:0] == 4'b1000);
    assign bus.cond_pass  = cond_eval(cond_sel, flags_sel);
    assign bus.it_fault   = fault_q;

endmodule

// File: tb/tb_it_cond_unit.sv
// Bench for it_cond_unit: directed literal cases plus randomized traffic
// compared every cycle against a behavioural ITSTATE/condition model.
module tb_it_cond_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    it_cond_unit_if bus ();

    it_cond_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition rule: even codes give a base test on NZCV, odd codes invert it, 14/15 always.
    function automatic logic model_cond(input logic [3:0] code, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        if (code >= 4'd14) return 1'b1;
        case (code / 2)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return (code % 2 == 1) ? !base : base;
    endfunction

    logic [7:0] m_it;
    logic       m_fault;
    logic       model_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_it     <= 8'h00;
            m_fault  <= 1'b0;
            model_ok <= 1'b1;
        end else begin
            m_fault <= 1'b0;
            if (bus.exc_entry)
                m_it <= 8'h00;
            else if (bus.it_load) begin
                if (bus.it_mask == 0 || m_it % 16 != 0)
                    m_fault <= 1'b1;
                else
                    m_it <= bus.it_firstcond * 16 + bus.it_mask;
            end else if (bus.instr_retire && m_it % 16 != 0) begin
                if (m_it % 8 == 0)
                    m_it <= 8'h00;
                else
                    m_it <= (m_it / 32) * 32 + (m_it % 16) * 2;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            logic [3:0] code;
            logic [3:0] fl;
            code = (m_it % 16 != 0) ? m_it[7:4] : bus.instr_cond;
`ifdef IT_FLAG_FWD_EN
            fl = bus.flag_we ? bus.alu_flags : bus.apsr_flags;
`else
            fl = bus.apsr_flags;
`endif
            check("m_itstate",    bus.itstate,    m_it);
            check("m_in_it",      bus.in_it,      (m_it % 16) != 0);
            check("m_last_in_it", bus.last_in_it, (m_it % 16) == 8);
            check("m_it_fault",   bus.it_fault,   m_fault);
            check("m_cond_pass",  bus.cond_pass,  model_cond(code, fl));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.it_load      = 1'b0;
        bus.instr_retire = 1'b0;
        bus.exc_entry    = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] fc, input logic [3:0] mask);
        bus.it_load      = 1'b1;
        bus.it_firstcond = fc;
        bus.it_mask      = mask;
    endtask

    initial begin
        rst              = 1'b1;
        bus.apsr_flags   = 4'b0000;
        bus.alu_flags    = 4'b0000;
        bus.flag_we      = 1'b0;
        bus.it_load      = 1'b0;
        bus.it_firstcond = 4'h0;
        bus.it_mask      = 4'h0;
        bus.instr_retire = 1'b0;
        bus.instr_cond   = 4'hE;
        bus.exc_entry    = 1'b0;
        tick();
        tick();
        check("rst_itstate", bus.itstate, 8'h00);
        check("rst_in_it",   bus.in_it, 1'b0);
        check("rst_last",    bus.last_in_it, 1'b0);
        check("rst_fault",   bus.it_fault, 1'b0);
        check("rst_cond",    bus.cond_pass, 1'b1);
        rst = 1'b0;
        tick();

        // ITTE EQ with Z=1
        bus.apsr_flags = 4'b0100;
        load(4'h0, 4'h6); tick();
        check("itte_load", bus.itstate, 8'h06);
        check("itte_cond0", bus.cond_pass, 1'b1);
        bus.instr_retire = 1'b1; tick();
        check("itte_r1", bus.itstate, 8'h0C);
        check("itte_cond1", bus.cond_pass, 1'b1);
        bus.instr_retire = 1'b1; tick();
        check("itte_r2", bus.itstate, 8'h18);
        check("itte_last", bus.last_in_it, 1'b1);
        check("itte_cond2_ne", bus.cond_pass, 1'b0);
        bus.instr_retire = 1'b1; tick();
        check("itte_r3", bus.itstate, 8'h00);
        check("itte_exit", bus.in_it, 1'b0);

        // Condition table outside a block
        bus.apsr_flags = 4'b1000;
        bus.instr_cond = 4'b1011; #1 check("cond_lt", bus.cond_pass, 1'b1);
        bus.instr_cond = 4'b1010; #1 check("cond_ge", bus.cond_pass, 1'b0);
        bus.instr_cond = 4'b1100; #1 check("cond_gt", bus.cond_pass, 1'b0);
        bus.instr_cond = 4'b1101; #1 check("cond_le", bus.cond_pass, 1'b1);
        bus.apsr_flags = 4'b0110;
        bus.instr_cond = 4'b1000; #1 check("cond_hi", bus.cond_pass, 1'b0);
        bus.instr_cond = 4'b1001; #1 check("cond_ls", bus.cond_pass, 1'b1);
        bus.instr_cond = 4'hE;

        // Illegal loads
        load(4'h3, 4'h0); tick();
        check("ill_mask0_it", bus.itstate, 8'h00);
        check("ill_mask0_fault", bus.it_fault, 1'b1);
        tick();
        check("ill_mask0_pulse", bus.it_fault, 1'b0);
        load(4'h0, 4'h6); tick();
        bus.instr_retire = 1'b1; tick();
        load(4'h3, 4'h4); tick();
        check("ill_nest_it", bus.itstate, 8'h0C);
        check("ill_nest_fault", bus.it_fault, 1'b1);
        tick();
        check("ill_nest_pulse", bus.it_fault, 1'b0);

        // Exception entry beats retire
        bus.instr_retire = 1'b1; tick();
        check("pre_exc", bus.itstate, 8'h18);
        bus.exc_entry = 1'b1; bus.instr_retire = 1'b1; tick();
        check("exc_clear", bus.itstate, 8'h00);

        // Reset mid-block
        load(4'h0, 4'h6); tick();
        rst = 1'b1; bus.instr_retire = 1'b1; load(4'h2, 4'h4); tick();
        check("rstmid_it", bus.itstate, 8'h00);
        check("rstmid_init", bus.in_it, 1'b0);
        check("rstmid_last", bus.last_in_it, 1'b0);
        check("rstmid_fault", bus.it_fault, 1'b0);
        check("rstmid_cond", bus.cond_pass, 1'b1);
        rst = 1'b0;

        // Load wins over simultaneous retire
        load(4'h1, 4'h8); bus.instr_retire = 1'b1; tick();
        check("ld_ret_it", bus.itstate, 8'h18);
        check("ld_ret_last", bus.last_in_it, 1'b1);
        bus.instr_retire = 1'b1; tick();
        check("ld_ret_exit", bus.itstate, 8'h00);

        // Forwarding path
        bus.apsr_flags = 4'b0000; bus.alu_flags = 4'b0100; bus.flag_we = 1'b1;
        bus.instr_cond = 4'b0000;
`ifdef IT_FLAG_FWD_EN
        #1 check("fwd_eq", bus.cond_pass, 1'b1);
`else
        #1 check("fwd_eq", bus.cond_pass, 1'b0);
`endif
        bus.flag_we = 1'b0; bus.instr_cond = 4'hE;
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 63) == 0);
            bus.exc_entry    = ($urandom_range(0, 15) == 0);
            bus.it_load      = ($urandom_range(0, 5) == 0);
            bus.it_firstcond = 4'($urandom_range(0, 15));
            bus.it_mask      = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            bus.instr_retire = $urandom_range(0, 1) == 1;
            bus.instr_cond   = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            bus.apsr_flags   = 4'($urandom_range(0, 15));
            bus.alu_flags    = 4'($urandom_range(0, 15));
            bus.flag_we      = $urandom_range(0, 1) == 1;
            @(negedge clk);
            #1;
        end
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
